// File: rtl/frame_merge.sv
// frame_merge
//   Merges the ARP and UDP transmit byte streams onto the single MAC TX
//   stream. Whole frames only: the granted source owns the output until its
//   last beat is accepted. ARP wins when both sources are waiting in IDLE.
//   Each frame is tagged with a 35-bit type word: [34:3] destination IP
//   (0 for ARP) and [2:0] 3'b001 for ARP or 3'b010 for UDP. After every frame,
//   GAP_CYCLES extra idle cycles are enforced before the next grant.
//
// Parameters
//   GAP_CYCLES          extra idle cycles after each frame (0..255)
//
// Ports
//   logic_clk           clock, rising edge
//   logic_rstn          asynchronous active-low reset
//   arp_tdata_in/_tvalid_in/_tlast_in, arp_tready_out   ARP source stream
//   udp_tdata_in/_tvalid_in/_tlast_in, udp_tready_out   UDP source stream
//   udp_tip_in          UDP destination IP, stable for the whole frame
//   net_tmac_data_out/_valid_out/_last_out, net_tmac_ready_in   MAC stream
//   net_tmac_type_out   frame type/IP word, latched at grant
module frame_merge #(
  parameter int GAP_CYCLES = 2
) (
  input  logic        logic_clk,
  input  logic        logic_rstn,
  input  logic [7:0]  arp_tdata_in,
  input  logic        arp_tvalid_in,
  output logic        arp_tready_out,
  input  logic        arp_tlast_in,
  input  logic [7:0]  udp_tdata_in,
  input  logic        udp_tvalid_in,
  output logic        udp_tready_out,
  input  logic        udp_tlast_in,
  input  logic [31:0] udp_tip_in,
  output logic [7:0]  net_tmac_data_out,
  output logic        net_tmac_valid_out,
  input  logic        net_tmac_ready_in,
  output logic        net_tmac_last_out,
  output logic [34:0] net_tmac_type_out
);

  localparam logic [7:0] GAP_LIMIT = 8'(GAP_CYCLES);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARP_TX = 2'd1,
    UDP_TX = 2'd2,
    GAP    = 2'd3
  } state_t;

  state_t      state;
  logic [7:0]  gap_cnt;

  logic [7:0]  data_p0;
  logic        last_p0;
  logic        vld_p0;
  logic [34:0] type_p0;

  logic        out_free;
  logic        arp_acc;
  logic        udp_acc;
  logic        src_acc;
  logic [7:0]  src_data;
  logic        src_last;

  // The output stage can take a new beat when it is empty or being drained.
  assign out_free       = !vld_p0 || net_tmac_ready_in;
  assign arp_tready_out = (state == ARP_TX) && out_free;
  assign udp_tready_out = (state == UDP_TX) && out_free;

  assign arp_acc  = arp_tvalid_in && arp_tready_out;
  assign udp_acc  = udp_tvalid_in && udp_tready_out;
  assign src_acc  = arp_acc || udp_acc;
  assign src_data = (state == ARP_TX) ? arp_tdata_in : udp_tdata_in;
  assign src_last = (state == ARP_TX) ? arp_tlast_in : udp_tlast_in;

  always_ff @(posedge logic_clk or negedge logic_rstn) begin
    if (!logic_rstn) begin
      state   <= IDLE;
      gap_cnt <= 8'd0;
      data_p0 <= 8'd0;
      last_p0 <= 1'b0;
      vld_p0  <= 1'b0;
      type_p0 <= 35'd0;
    end else begin
      // ---- stage p0: single registered output beat ----
      if (src_acc) begin
        data_p0 <= src_data;
        last_p0 <= src_last;
        vld_p0  <= 1'b1;
      end else if (net_tmac_ready_in) begin
        vld_p0  <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (arp_tvalid_in) begin
            state   <= ARP_TX;
            type_p0 <= {32'h0, 3'b001};
          end else if (udp_tvalid_in) begin
            state   <= UDP_TX;
            type_p0 <= {udp_tip_in, 3'b010};
          end
        end
        ARP_TX: begin
          if (arp_acc && arp_tlast_in) begin
            state   <= GAP;
            gap_cnt <= 8'd0;
          end
        end
        UDP_TX: begin
          if (udp_acc && udp_tlast_in) begin
            state   <= GAP;
            gap_cnt <= 8'd0;
          end
        end
        GAP: begin
          // Idle cycles only count once the last beat has left the output.
          if (!vld_p0) begin
            if (gap_cnt == GAP_LIMIT) begin
              state <= IDLE;
            end else begin
              gap_cnt <= gap_cnt + 8'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign net_tmac_data_out  = data_p0;
  assign net_tmac_last_out  = last_p0;
  assign net_tmac_valid_out = vld_p0;
  assign net_tmac_type_out  = type_p0;

endmodule
